// File: rtl/priority_decoder.sv
// 4-line priority encoder (d3 highest) with registered 2-bit index and valid flag.
// Code 00 is only meaningful when valid is high.
module priority_decoder (
    input  logic clk,
    input  logic rst_n,
    input  logic d3,
    input  logic d2,
    input  logic d1,
    input  logic d0,
    output logic y1,
    output logic y0,
    output logic valid
);

    logic [1:0] code_d;
    logic [1:0] code_q;
    logic       valid_d;
    logic       valid_q;

    always_comb begin
        code_d  = '0;
        valid_d = 1'b1;
        if (d3) begin
            code_d = 2'b11;
        end else if (d2) begin
            code_d = 2'b10;
        end else if (d1) begin
            code_d = 2'b01;
        end else if (d0) begin
            code_d = 2'b00;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign y1    = code_q[1];
    assign y0    = code_q[0];
    assign valid = valid_q;

endmodule

// File: tb/tb_priority_decoder.sv
// Scoreboard bench for priority_decoder: stimulus pushes expected {y1,y0,valid},
// a monitor pops one entry after every rising edge and compares.
module tb_priority_decoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] d;
    logic       y1;
    logic       y0;
    logic       valid;

    int checks;
    int failures;

    logic [2:0] exp_q[$];
    logic [2:0] last_exp;

    priority_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d3    (d[3]),
        .d2    (d[2]),
        .d1    (d[1]),
        .d0    (d[0]),
        .y1    (y1),
        .y0    (y0),
        .valid (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: index of the highest set request line, valid if any line is set.
    function automatic logic [2:0] model(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) return {2'(i), 1'b1};
        end
        return 3'b000;
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got y1y0=%b%b valid=%b, expected y1y0=%b%b valid=%b",
                     name, act[2], act[1], act[0], exp[2], exp[1], exp[0]);
        end
    endtask

    // Called at a falling edge: the next rising edge samples v.
    task automatic drive(input logic [3:0] v);
        d = v;
        exp_q.push_back(model(v));
        last_exp = model(v);
    endtask

    // Monitor: the DUT presents a fresh result after every rising edge.
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            check("scoreboard", {y1, y0, valid}, exp_q.pop_front());
        end
    end

    localparam logic [3:0] DIRECTED [11] = '{
        4'b0000, 4'b0000,
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b0011, 4'b0110, 4'b1111, 4'b1001, 4'b0101
    };

    initial begin
        checks   = 0;
        failures = 0;
        last_exp = '0;
        rst_n    = 1'b0;
        d        = 4'b1111;

        // Reset held with all requests high: outputs stay cleared across edges.
        #1;
        check("reset_initial", {y1, y0, valid}, 3'b000);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold", {y1, y0, valid}, 3'b000);
        end

        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1111);

        foreach (DIRECTED[i]) begin
            @(negedge clk);
            drive(DIRECTED[i]);
        end

        // Glitch: pulse d3 within the low phase, restore before the sampling edge.
        @(negedge clk);
        drive(4'b0001);
        @(posedge clk);
        #2;
        begin
            logic [2:0] held;
            held = last_exp;
            #4;
            d[3] = 1'b1;
            #1;
            check("glitch_hold", {y1, y0, valid}, held);
            d[3] = 1'b0;
        end
        @(negedge clk);
        drive(4'b0001);
        @(negedge clk);
        drive(4'b0001);

        // Async reset mid-stream from 11/1.
        @(negedge clk);
        drive(4'b1000);
        @(negedge clk);
        drive(4'b1010);
        @(posedge clk);
        #2;
        check("pre_async_reset", {y1, y0, valid}, 3'b111);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("async_reset", {y1, y0, valid}, 3'b000);
        d = 4'b1111;
        @(posedge clk);
        #1;
        check("async_reset_hold", {y1, y0, valid}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0100);

        // Randomised traffic.
        repeat (300) begin
            @(negedge clk);
            drive(4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected results left unchecked, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
